load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/data_mem.sv | 26 ++
 rtl/lsu_align.sv | 55 +++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, FSM states,
// and small address-offset helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    STORE,
    RESP
  } lsu_state_e;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SZ_WORD : size;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

  // Drops the low offset bits that the access size cannot address.
  function automatic logic [1:0] trunc_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: return {off[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/data_mem.sv
// Word-organised data memory: combinational read from addr, write on the
// rising edge while MemWrite is high.
module data_mem #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH_W = 6
) (
  input  logic              clk,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data
);

  logic [31:0]        r_mem [2**DEPTH_W];
  logic [DEPTH_W-1:0] w_idx;
  logic               w_unused_bits;

  assign w_idx         = addr[DEPTH_W+1:2];
  assign w_unused_bits = ^{addr[ADDR_W-1:DEPTH_W+2], addr[1:0]};
  assign read_data     = r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (MemWrite) r_mem[w_idx] <= write_data;
  end

endmodule

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension,
// and store merge of byte/half data into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_size)
      SZ_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  always_comb begin
    o_merge_data = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        case (i_off)
          2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
          2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
          2'd2:    o_merge_data[23:16] = i_wdata[7:0];
          default: o_merge_data[31:24] = i_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (i_off[1]) o_merge_data[31:16] = i_wdata[15:0];
        else          o_merge_data[15:0]  = i_wdata[15:0];
      end
      default: o_merge_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request/response handshake to a single-port data memory,
// with read-modify-write for sub-word stores.
// Optional misalignment error path: define LSU_MISALIGN_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data
);

  lsu_state_e        r_state;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_write_data;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;

  logic [1:0]        w_size;
  logic [1:0]        w_off;
  logic              w_err;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merge_data;

  assign w_size = norm_size(req_size);
  // Aligned offsets pass through unchanged, so truncation is harmless when
  // the error path is enabled and is the required behaviour when it is not.
  assign w_off  = trunc_off(w_size, req_addr[1:0]);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_err = misaligned(w_size, req_addr[1:0]);
`else
  assign w_err = 1'b0;
`endif

  lsu_align u_align (
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_off        (r_off),
    .i_rdata      (read_data),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_addr       <= '0;
      r_write_data <= '0;
      r_size       <= SZ_BYTE;
      r_unsigned   <= 1'b0;
      r_off        <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_size      <= w_size;
            r_unsigned  <= req_unsigned;
            r_off       <= w_off;
            r_wdata     <= req_wdata;
            r_addr      <= {req_addr[ADDR_W-1:2], 2'b00};
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (!req_we) begin
              r_state    <= LOAD;
              r_mem_read <= 1'b1;
            end else if (w_size == SZ_WORD) begin
              r_state      <= STORE;
              r_mem_write  <= 1'b1;
              r_write_data <= req_wdata;
            end else begin
              r_state    <= RMW_RD;
              r_mem_read <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_mem_read   <= 1'b0;
          r_resp_rdata <= w_load_data;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RMW_RD: begin
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b1;
          r_write_data <= w_merge_data;
          r_state      <= STORE;
        end
        STORE: begin
          r_mem_write  <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign MemRead    = r_mem_read;
  assign MemWrite   = r_mem_write;
  assign addr       = r_addr;
  assign write_data = r_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit connected to data_mem.
module tb_load_store_unit;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          MemWrite;
  logic          MemRead;
  logic [AW-1:0] addr;
  logic [31:0]   write_data;
  logic [31:0]   read_data;

  int          errors = 0;
  int          checks = 0;
  int          t_lat, t_nrd, t_nwr, overlap = 0;
  logic [31:0] t_rd, t_wd, held;
  logic        t_err;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemWrite(MemWrite), .MemRead(MemRead), .addr(addr),
    .write_data(write_data), .read_data(read_data)
  );

  data_mem #(.ADDR_W(AW), .DEPTH_W(6)) u_mem (
    .clk(clk), .MemWrite(MemWrite), .addr(addr),
    .write_data(write_data), .read_data(read_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (MemRead) t_nrd++;
    if (MemWrite) begin
      t_nwr++;
      t_wd = write_data;
    end
    if (MemRead && MemWrite) overlap++;
  endtask

  // One complete transaction; latency counts edges from accept to the first
  // edge at which resp_valid is high.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    t_lat = 1; t_nrd = 0; t_nwr = 0; t_wd = '0;
    sample();
    while (!resp_valid && t_lat < 20) begin
      @(negedge clk);
      t_lat++;
      sample();
    end
    t_rd  = resp_rdata;
    t_err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"},  {31'd0, req_ready},  32'd1);
    check({pfx, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({pfx, "_resp_rdata"}, resp_rdata,          32'd0);
    check({pfx, "_resp_err"},   {31'd0, resp_err},   32'd0);
    check({pfx, "_MemRead"},    {31'd0, MemRead},    32'd0);
    check({pfx, "_MemWrite"},   {31'd0, MemWrite},   32'd0);
    check({pfx, "_addr"},       addr,                32'd0);
    check({pfx, "_write_data"}, write_data,          32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 32'd4, 32'h1234ABCD);
    check("wst_lat", t_lat, 32'd2);
    check("wst_nwr", t_nwr, 32'd1);
    check("wst_nrd", t_nrd, 32'd0);
    check("wst_wdata", t_wd, 32'h1234ABCD);
    check("wst_rdata", t_rd, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
    check("wld_lat", t_lat, 32'd2);
    check("wld_nrd", t_nrd, 32'd1);
    check("wld_nwr", t_nwr, 32'd0);
    check("wld_rdata", t_rd, 32'h1234ABCD);
    check("wld_err", {31'd0, t_err}, 32'd0);

    // Byte store via read-modify-write; upper wdata bits must be ignored
    do_req(1'b1, 2'b10, 1'b0, 32'd8, 32'hBEEFBEEF);
    do_req(1'b1, 2'b00, 1'b0, 32'd9, 32'hFFFFFF5A);
    check("bst_lat", t_lat, 32'd3);
    check("bst_nrd", t_nrd, 32'd1);
    check("bst_nwr", t_nwr, 32'd1);
    check("bst_wdata", t_wd, 32'hBEEF5AEF);
    do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
    check("bst_readback", t_rd, 32'hBEEF5AEF);

    // Sub-word loads with extension
    do_req(1'b0, 2'b00, 1'b0, 32'd11, 32'h0);
    check("lb_s_11", t_rd, 32'hFFFFFFBE);
    do_req(1'b0, 2'b00, 1'b1, 32'd11, 32'h0);
    check("lb_u_11", t_rd, 32'h000000BE);
    do_req(1'b0, 2'b01, 1'b0, 32'd10, 32'h0);
    check("lh_s_10", t_rd, 32'hFFFFBEEF);
    do_req(1'b0, 2'b01, 1'b1, 32'd10, 32'h0);
    check("lh_u_10", t_rd, 32'h0000BEEF);
    do_req(1'b0, 2'b00, 1'b0, 32'd9, 32'h0);
    check("lb_s_9", t_rd, 32'h0000005A);
    do_req(1'b0, 2'b11, 1'b0, 32'd8, 32'h0);
    check("lw_reserved_size", t_rd, 32'hBEEF5AEF);

    // Half store into the upper lane
    do_req(1'b1, 2'b01, 1'b0, 32'd10, 32'hAAAA1357);
    check("hst_lat", t_lat, 32'd3);
    check("hst_wdata", t_wd, 32'h13575AEF);

    // Misaligned word load
    do_req(1'b0, 2'b10, 1'b0, 32'd6, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_err", {31'd0, t_err}, 32'd1);
    check("mis_nrd", t_nrd, 32'd0);
    check("mis_nwr", t_nwr, 32'd0);
    check("mis_lat", t_lat, 32'd1);
`else
    check("mis_err", {31'd0, t_err}, 32'd0);
    check("mis_rdata", t_rd, 32'h1234ABCD);
    do_req(1'b0, 2'b01, 1'b0, 32'd9, 32'h0);
    check("mis_half_trunc", t_rd, 32'h00005AEF);
`endif

    // Response backpressure with a competing request
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_valid0", {31'd0, resp_valid}, 32'd1);
    held = resp_rdata;
    check("bp_rdata0", held, 32'h1234ABCD);
    req_valid = 1'b1; req_addr = 32'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid_hold", {31'd0, resp_valid}, 32'd1);
      check("bp_rdata_hold", resp_rdata, 32'h1234ABCD);
      check("bp_ready_low", {31'd0, req_ready}, 32'd0);
      check("bp_no_read", {31'd0, MemRead}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_after_hs_ready", {31'd0, req_ready}, 32'd1);
    check("bp_after_hs_valid", {31'd0, resp_valid}, 32'd0);
    check("bp_not_accepted", {31'd0, MemRead}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_accepted_read", {31'd0, MemRead}, 32'd1);
    check("bp_accepted_addr", addr, 32'd8);
    @(negedge clk);
    check("bp_second_valid", {31'd0, resp_valid}, 32'd1);
    check("bp_second_rdata", resp_rdata, 32'h13575AEF);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;

    // Reset during the read phase of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'd4;
    req_wdata = 32'h00000077;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_rst_inread", {31'd0, MemRead}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
    check("midrst_mem_intact", t_rd, 32'h1234ABCD);

    check("strobe_overlap", overlap, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
